// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;
  localparam int   LAT_W   = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between CPU and debug requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise debug has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last_grant,
  output logic win_valid,
  output logic win_owner
);

  assign win_valid = cpu_req | dbg_req;

`ifdef MEM_ARB_RR_EN
  // On a tie the port that lost the previous grant goes next.
  always_comb begin
    win_owner = dbg_req ? OWN_DBG : OWN_CPU;
    if (cpu_req && dbg_req) begin
      win_owner = ~last_grant;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;
  assign win_owner = dbg_req ? OWN_DBG : OWN_CPU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises CPU and debug accesses onto the shared memory bus.
// Falling-edge design; MEM_ARB_RR_EN adds a last_grant register for round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_RW,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic [15:0] dbg_adr,
  input  logic        dbg_RW,
  input  logic [7:0]  dbg_wdata,
  output logic [7:0]  dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_en,
  output logic [15:0] mem_adr,
  output logic        mem_RW,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_data_in,
  output logic        owner
);

  state_t             r_state;
  state_t             w_next;
  logic               r_owner;
  logic               r_mem_en;
  logic               r_mem_rw;
  logic [15:0]        r_mem_adr;
  logic [7:0]         r_mem_wdata;
  logic [7:0]         r_cpu_rdata;
  logic [7:0]         r_dbg_rdata;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               w_win_valid;
  logic               w_win_owner;
  logic               w_last_grant;
  logic               w_sel_owner;
  logic               w_enter_access;

  mem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .last_grant (w_last_grant),
    .win_valid  (w_win_valid),
    .win_owner  (w_win_owner)
  );

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;
  always_ff @(negedge clk) begin
    if (!n_reset) begin
      r_last_grant <= OWN_CPU;
    end else if (r_state == IDLE && w_win_valid) begin
      r_last_grant <= w_win_owner;
    end
  end
  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = OWN_CPU;
`endif

  always_ff @(negedge clk) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_win_valid) w_next = (w_win_owner == r_owner) ? ACCESS : TURN;
      TURN:    w_next = ACCESS;
      ACCESS:  if (r_lat_cnt == '0) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // After a turnaround the owner register already names the winner.
  assign w_sel_owner    = (r_state == TURN) ? r_owner : w_win_owner;
  assign w_enter_access = (w_next == ACCESS) && (r_state != ACCESS);

  always_ff @(negedge clk) begin
    if (!n_reset) begin
      r_owner     <= OWN_CPU;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b1;
      r_mem_adr   <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_lat_cnt   <= '0;
    end else begin
      if (r_state == IDLE && w_next == TURN) begin
        r_owner <= w_win_owner;
      end
      if (w_enter_access) begin
        r_mem_en    <= 1'b1;
        r_mem_adr   <= (w_sel_owner == OWN_DBG) ? dbg_adr   : cpu_adr;
        r_mem_rw    <= (w_sel_owner == OWN_DBG) ? dbg_RW    : cpu_RW;
        r_mem_wdata <= (w_sel_owner == OWN_DBG) ? dbg_wdata : cpu_wdata;
        r_lat_cnt   <= LAT_W'(MEM_LAT - 1);
      end else if (r_state == ACCESS) begin
        if (r_lat_cnt == '0) begin
          r_mem_en <= 1'b0;
          r_mem_rw <= 1'b1;
          if (r_mem_rw && r_owner == OWN_DBG) r_dbg_rdata <= mem_data_in;
          if (r_mem_rw && r_owner == OWN_CPU) r_cpu_rdata <= mem_data_in;
        end else begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
        end
      end
    end
  end

  assign cpu_ack   = (r_state == ACK) && (r_owner == OWN_CPU);
  assign dbg_ack   = (r_state == ACK) && (r_owner == OWN_DBG);
  assign cpu_stall = cpu_req &&
                     !((r_owner == OWN_CPU) && (r_state == ACCESS || r_state == ACK));
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign mem_en    = r_mem_en;
  assign mem_adr   = r_mem_adr;
  assign mem_RW    = r_mem_rw;
  assign mem_wdata = r_mem_wdata;
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level schedule model.
module tb_mem_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        n_reset, cpu_req, cpu_rw, dbg_req, dbg_rw;
  logic [15:0] cpu_adr, dbg_adr;
  logic [7:0]  cpu_wd, dbg_wd, mem_din;
  logic [7:0]  cpu_rd, dbg_rd, mem_wd;
  logic [15:0] mem_adr;
  logic        cpu_ack, cpu_stall, dbg_ack, mem_en, mem_rw, owner;

  logic        d3_n_reset, d3_cpu_req, d3_cpu_rw, d3_dbg_req, d3_dbg_rw;
  logic [15:0] d3_cpu_adr, d3_dbg_adr;
  logic [7:0]  d3_cpu_wd, d3_dbg_wd, d3_mem_din;
  logic [7:0]  d3_cpu_rd, d3_dbg_rd, d3_mem_wd;
  logic [15:0] d3_mem_adr;
  logic        d3_cpu_ack, d3_cpu_stall, d3_dbg_ack, d3_mem_en, d3_mem_rw, d3_owner;

  mem_arbiter #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .n_reset(n_reset),
    .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_RW(cpu_rw), .cpu_wdata(cpu_wd),
    .cpu_rdata(cpu_rd), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_adr(dbg_adr), .dbg_RW(dbg_rw), .dbg_wdata(dbg_wd),
    .dbg_rdata(dbg_rd), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_adr(mem_adr), .mem_RW(mem_rw), .mem_wdata(mem_wd),
    .mem_data_in(mem_din), .owner(owner)
  );

  mem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .n_reset(d3_n_reset),
    .cpu_req(d3_cpu_req), .cpu_adr(d3_cpu_adr), .cpu_RW(d3_cpu_rw), .cpu_wdata(d3_cpu_wd),
    .cpu_rdata(d3_cpu_rd), .cpu_ack(d3_cpu_ack), .cpu_stall(d3_cpu_stall),
    .dbg_req(d3_dbg_req), .dbg_adr(d3_dbg_adr), .dbg_RW(d3_dbg_rw), .dbg_wdata(d3_dbg_wd),
    .dbg_rdata(d3_dbg_rd), .dbg_ack(d3_dbg_ack),
    .mem_en(d3_mem_en), .mem_adr(d3_mem_adr), .mem_RW(d3_mem_rw), .mem_wdata(d3_mem_wd),
    .mem_data_in(d3_mem_din), .owner(d3_owner)
  );

  typedef struct {
    bit          rw;
    logic [15:0] adr;
    logic [7:0]  wd;
    logic [7:0]  md;
    bit          early;
    int          s;
  } txn_t;

  typedef struct {
    bit          en, cack, dack, own, cact, cap, rdu, rw;
    logic [15:0] adr;
    logic [7:0]  wd, md, rdv;
  } samp_t;

  txn_t  cq[$];
  txn_t  dq[$];
  samp_t sch[256];
  int    n_samp;
  bit    m_owner, m_last;
  logic [7:0] m_crd, m_drd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input bit rw, input logic [15:0] adr, input logic [7:0] wd,
                              input logic [7:0] md, input bit early);
    txn_t x;
    x.rw = rw; x.adr = adr; x.wd = wd; x.md = md; x.early = early; x.s = 0;
    return x;
  endfunction

  function automatic bit tie_win();
`ifdef MEM_ARB_RR_EN
    return ~m_last;
`else
    return 1'b1;
`endif
  endfunction

  // Grants are whole slots: optional turnaround, LAT access cycles, ack, idle.
  task automatic plan();
    int t, s, ci, di;
    bit win;
    txn_t x;
    t = 0; ci = 0; di = 0;
    for (int j = 0; j < 256; j++) begin
      sch[j] = '{default: 0};
      sch[j].own = m_owner;
    end
    while (ci < cq.size() || di < dq.size()) begin
      if (ci < cq.size() && di < dq.size()) win = tie_win();
      else win = (di < dq.size());
      x = win ? dq[di] : cq[ci];
      s = t + ((win != m_owner) ? 1 : 0);
      m_owner = win;
      m_last  = win;
      for (int j = t; j < 256; j++) sch[j].own = win;
      for (int j = s; j < s + LAT; j++) begin
        sch[j].en = 1; sch[j].adr = x.adr; sch[j].rw = x.rw; sch[j].wd = x.wd;
      end
      for (int j = s; j <= s + LAT; j++) sch[j].cact = ~win;
      sch[s+LAT-1].cap = 1;
      sch[s+LAT-1].md  = x.md;
      sch[s+LAT].rdu   = x.rw;
      sch[s+LAT].rdv   = x.md;
      if (win) begin
        sch[s+LAT].dack = 1; dq[di].s = s; di++;
      end else begin
        sch[s+LAT].cack = 1; cq[ci].s = s; ci++;
      end
      t = s + LAT + 2;
    end
    n_samp = t;
  endtask

  task automatic present(input bit port, input txn_t x);
    if (port) begin
      dbg_req = 1; dbg_rw = x.rw; dbg_adr = x.adr; dbg_wd = x.wd;
    end else begin
      cpu_req = 1; cpu_rw = x.rw; cpu_adr = x.adr; cpu_wd = x.wd;
    end
  endtask

  task automatic run_scn(input string tag);
    int ci, di;
    ci = 0; di = 0;
    plan();
    if (cq.size() > 0) present(1'b0, cq[0]);
    if (dq.size() > 0) present(1'b1, dq[0]);
    mem_din = 8'($urandom);
    for (int j = 0; j < n_samp; j++) begin
      @(posedge clk);
      if (sch[j].cack && sch[j].rdu) m_crd = sch[j].rdv;
      if (sch[j].dack && sch[j].rdu) m_drd = sch[j].rdv;
      chk({tag, ".mem_en"}, mem_en, sch[j].en);
      chk({tag, ".mem_RW"}, mem_rw, sch[j].en ? sch[j].rw : 1'b1);
      if (sch[j].en) begin
        chk({tag, ".mem_adr"}, mem_adr, sch[j].adr);
        chk({tag, ".mem_wdata"}, mem_wd, sch[j].wd);
      end
      chk({tag, ".cpu_ack"}, cpu_ack, sch[j].cack);
      chk({tag, ".dbg_ack"}, dbg_ack, sch[j].dack);
      chk({tag, ".owner"}, owner, sch[j].own);
      chk({tag, ".cpu_stall"}, cpu_stall, cpu_req & ~sch[j].cact);
      chk({tag, ".cpu_rdata"}, cpu_rd, m_crd);
      chk({tag, ".dbg_rdata"}, dbg_rd, m_drd);
      if (ci < cq.size() && cq[ci].early && cq[ci].s == j) begin
        cpu_req = 0; cpu_adr = ~cpu_adr; cpu_wd = ~cpu_wd; cpu_rw = ~cpu_rw;
      end
      if (di < dq.size() && dq[di].early && dq[di].s == j) begin
        dbg_req = 0; dbg_adr = ~dbg_adr; dbg_wd = ~dbg_wd; dbg_rw = ~dbg_rw;
      end
      if (sch[j].cack) begin
        ci++;
        if (ci < cq.size()) present(1'b0, cq[ci]); else cpu_req = 0;
      end
      if (sch[j].dack) begin
        di++;
        if (di < dq.size()) present(1'b1, dq[di]); else dbg_req = 0;
      end
      mem_din = sch[j].cap ? sch[j].md : 8'($urandom);
    end
    cq.delete();
    dq.delete();
  endtask

  initial begin
    int nc, nd;
    n_reset = 0; cpu_req = 0; cpu_rw = 1; cpu_adr = 0; cpu_wd = 0;
    dbg_req = 0; dbg_rw = 1; dbg_adr = 0; dbg_wd = 0; mem_din = 0;
    d3_n_reset = 0; d3_cpu_req = 0; d3_cpu_rw = 1; d3_cpu_adr = 0; d3_cpu_wd = 0;
    d3_dbg_req = 0; d3_dbg_rw = 1; d3_dbg_adr = 0; d3_dbg_wd = 0; d3_mem_din = 0;
    m_owner = 0; m_last = 0; m_crd = 0; m_drd = 0;
    repeat (3) @(posedge clk);
    n_reset = 1; d3_n_reset = 1;
    @(posedge clk);

    chk("rst.mem_en", mem_en, 1'b0);
    chk("rst.mem_RW", mem_rw, 1'b1);
    chk("rst.mem_adr", mem_adr, 16'h0000);
    chk("rst.mem_wdata", mem_wd, 8'h00);
    chk("rst.cpu_ack", cpu_ack, 1'b0);
    chk("rst.dbg_ack", dbg_ack, 1'b0);
    chk("rst.cpu_rdata", cpu_rd, 8'h00);
    chk("rst.dbg_rdata", dbg_rd, 8'h00);
    chk("rst.cpu_stall", cpu_stall, 1'b0);
    chk("rst.owner", owner, 1'b0);
    chk("rst3.mem_en", d3_mem_en, 1'b0);

    cq.push_back(mk(1'b1, 16'h1234, 8'h00, 8'hA5, 1'b0));
    run_scn("cpu_rd");
    dq.push_back(mk(1'b0, 16'h0200, 8'h5A, 8'h3C, 1'b0));
    run_scn("dbg_wr");
    cq.push_back(mk(1'b1, 16'h1111, 8'h00, 8'h11, 1'b0));
    dq.push_back(mk(1'b1, 16'h2222, 8'h00, 8'h22, 1'b0));
    run_scn("tie");
    cq.push_back(mk(1'b1, 16'h3001, 8'h00, 8'h31, 1'b0));
    cq.push_back(mk(1'b0, 16'h3002, 8'hC2, 8'h32, 1'b0));
    dq.push_back(mk(1'b1, 16'h4001, 8'h00, 8'h41, 1'b0));
    dq.push_back(mk(1'b1, 16'h4002, 8'h00, 8'h42, 1'b0));
    run_scn("held4");
    dq.push_back(mk(1'b1, 16'h0345, 8'h00, 8'h66, 1'b1));
    run_scn("dbg_drop");

    for (int it = 0; it < 40; it++) begin
      nc = $urandom_range(0, 2);
      nd = $urandom_range(0, 2);
      for (int k = 0; k < nc; k++)
        cq.push_back(mk(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                        ($urandom_range(0, 5) == 0)));
      for (int k = 0; k < nd; k++)
        dq.push_back(mk(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                        ($urandom_range(0, 5) == 0)));
      run_scn("rand");
    end

    // Three-cycle latency read, then a second read aborted by reset mid-access.
    d3_cpu_req = 1; d3_cpu_adr = 16'h4321; d3_cpu_rw = 1; d3_mem_din = 8'h77;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      chk("lat3.mem_en", d3_mem_en, (j < 3));
      chk("lat3.cpu_ack", d3_cpu_ack, (j == 3));
      if (j == 3) begin
        chk("lat3.cpu_rdata", d3_cpu_rd, 8'h77);
        d3_cpu_req = 0;
      end
    end
    d3_cpu_req = 1; d3_cpu_adr = 16'h5555; d3_mem_din = 8'h99;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk);
      chk("abort.cpu_ack", d3_cpu_ack, 1'b0);
      chk("abort.mem_en", d3_mem_en, (j < 2));
      if (j == 0) chk("abort.mem_adr", d3_mem_adr, 16'h5555);
      if (j == 1) d3_n_reset = 0;
      if (j == 2) begin
        chk("abort.cpu_rdata", d3_cpu_rd, 8'h00);
        chk("abort.mem_RW", d3_mem_rw, 1'b1);
        chk("abort.owner", d3_owner, 1'b0);
        d3_n_reset = 1;
        d3_cpu_req = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
